// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared encodings for the memory arbiter slice
package cpu_mem_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA = 1'b1;
  localparam int DEF_MEM_DEPTH = 16;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes plus the memory-side bus
interface mem_arbiter_if;
  logic f_req;
  logic [15:0] f_addr;
  logic f_ack;
  logic [15:0] f_rdata;
  logic f_err;
  logic d_req;
  logic d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic d_ack;
  logic [15:0] d_rdata;
  logic d_err;
  logic mem_read;
  logic mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  modport slave (
    input f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_ack, f_rdata, f_err, d_ack, d_rdata, d_err, mem_read, mem_write, mem_addr, mem_wdata
  );
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input f_ack, f_rdata, f_err, d_ack, d_rdata, d_err, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: data-priority winner select with a fetch anti-starvation streak
module mem_arb_pick
  import cpu_mem_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic f_req_i,
  input  logic d_req_i,
  input  logic grant_i,
  output logic own_o
);
  localparam logic [3:0] MAX_L = 4'(MAX_DATA_STREAK);
  logic [3:0] streak_q, streak_d;
  assign own_o = (f_req_i && (!d_req_i || streak_q == MAX_L)) ? OWN_FETCH : OWN_DATA;
  // count data grants that bypassed a waiting fetch, saturating at the limit
  always_comb
    streak_d = !grant_i ? streak_q :
               (own_o == OWN_FETCH || !f_req_i) ? 4'd0 :
               (streak_q == MAX_L) ? streak_q : streak_q + 4'd1;
  // streak register
  always_ff @(posedge clk)
    if (rst) streak_q <= 4'd0;
    else streak_q <= streak_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter and IDLE/ISSUE/RESP sequencer for a single-port memory
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic CLK,
  input logic reset,
  mem_arbiter_if.slave bus
);
  localparam logic [16:0] DEPTH_L = 17'(MEM_DEPTH);
  logic [1:0] state_q, state_d;
  logic own_q, own_d, we_q, we_d, err_q, err_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
  logic grant, own, issue, f_ack, d_ack;
  logic [15:0] addr_sel;
  assign grant = state_q == IDLE && (bus.f_req || bus.d_req);
  mem_arb_pick #(.MAX_DATA_STREAK(MAX_DATA_STREAK)) u_pick (
    .clk(CLK),
    .rst(reset),
    .f_req_i(bus.f_req),
    .d_req_i(bus.d_req),
    .grant_i(grant),
    .own_o(own)
  );
  assign addr_sel = own == OWN_FETCH ? bus.f_addr : bus.d_addr;
  // next state and request latches, captured only on a grant
  always_comb begin
    state_d = state_q == IDLE ? (grant ? ISSUE : IDLE) : state_q == ISSUE ? RESP : IDLE;
    own_d = grant ? own : own_q;
    addr_d = grant ? addr_sel : addr_q;
    we_d = grant ? (own == OWN_DATA && bus.d_we) : we_q;
    wdata_d = grant ? (own == OWN_DATA ? bus.d_wdata : 16'd0) : wdata_q;
    err_d = grant ? ({1'b0, addr_sel} >= DEPTH_L) : err_q;
  end
  // state and latch registers
  always_ff @(posedge CLK)
    if (reset) begin
      state_q <= IDLE;
      own_q <= OWN_FETCH;
      we_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= 16'd0;
      wdata_q <= 16'd0;
    end else begin
      state_q <= state_d;
      own_q <= own_d;
      we_q <= we_d;
      err_q <= err_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  assign issue = state_q == ISSUE;
  assign bus.mem_read = issue && !we_q && !err_q;
  assign bus.mem_write = issue && we_q && !err_q;
  assign bus.mem_addr = issue ? addr_q : 16'd0;
  assign bus.mem_wdata = issue ? wdata_q : 16'd0;
  assign f_ack = state_q == RESP && own_q == OWN_FETCH;
  assign d_ack = state_q == RESP && own_q == OWN_DATA;
  assign bus.f_ack = f_ack;
  assign bus.d_ack = d_ack;
  assign bus.f_err = f_ack && err_q;
  assign bus.d_err = d_ack && err_q;
  assign bus.f_rdata = (f_ack && !err_q) ? bus.mem_rdata : 16'd0;
  assign bus.d_rdata = (d_ack && !we_q && !err_q) ? bus.mem_rdata : 16'd0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench with a behavioural 16x16 memory
module tb_mem_arbiter;
  logic CLK = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] mem [16];
  mem_arbiter_if bus ();
  mem_arbiter dut (.CLK(CLK), .reset(reset), .bus(bus));
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    if (bus.mem_write) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
    if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr[3:0]];
  end
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] RD = 6'b100000;
  localparam logic [5:0] WR = 6'b010000;
  localparam logic [5:0] FACK = 6'b001000;
  localparam logic [5:0] DACK = 6'b000010;
  localparam logic [5:0] DERR = 6'b000011;
  function automatic logic [5:0] fl();
    return {bus.mem_read, bus.mem_write, bus.f_ack, bus.f_err, bus.d_ack, bus.d_err};
  endfunction
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: flags observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h27E7;
    bus.mem_rdata = 16'd0;
    reset = 1'b1;
    bus.f_req = 1'b0;
    bus.f_addr = 16'd0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = 16'd0;
    bus.d_wdata = 16'd0;
    tick();
    tick();
    chk6("reset flags", fl(), NONE);
    chk16("reset buses", bus.mem_addr | bus.mem_wdata | bus.f_rdata | bus.d_rdata, 16'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk6("idle flags", fl(), NONE);
    end
    bus.f_req = 1'b1;
    bus.f_addr = 16'd0;
    tick();
    chk6("fetch issue", fl(), RD);
    chk16("fetch issue addr", bus.mem_addr, 16'd0);
    tick();
    chk6("fetch ack", fl(), FACK);
    chk16("fetch rdata", bus.f_rdata, 16'h27E7);
    bus.f_req = 1'b0;
    tick();
    chk6("fetch done", fl(), NONE);
    chk16("fetch rdata cleared", bus.f_rdata, 16'd0);
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 16'd5;
    bus.d_wdata = 16'hBEEF;
    tick();
    chk6("write issue", fl(), WR);
    chk16("write addr", bus.mem_addr, 16'd5);
    chk16("write wdata", bus.mem_wdata, 16'hBEEF);
    tick();
    chk6("write ack", fl(), DACK);
    chk16("write rdata zero", bus.d_rdata, 16'd0);
    bus.d_we = 1'b0;
    tick();
    chk6("read idle", fl(), NONE);
    tick();
    chk6("read issue", fl(), RD);
    chk16("read addr", bus.mem_addr, 16'd5);
    tick();
    chk6("read ack", fl(), DACK);
    chk16("read rdata", bus.d_rdata, 16'hBEEF);
    bus.d_we = 1'b1;
    bus.d_addr = 16'h0010;
    bus.d_wdata = 16'h1234;
    tick();
    tick();
    chk6("oor issue", fl(), NONE);
    chk16("oor addr", bus.mem_addr, 16'h0010);
    tick();
    chk6("oor ack err", fl(), DERR);
    chk16("oor rdata", bus.d_rdata, 16'd0);
    bus.d_we = 1'b0;
    bus.d_addr = 16'd0;
    tick();
    tick();
    chk6("addr0 issue", fl(), RD);
    tick();
    chk6("addr0 ack", fl(), DACK);
    chk16("addr0 unchanged", bus.d_rdata, 16'h27E7);
    bus.d_addr = 16'd5;
    bus.f_req = 1'b1;
    bus.f_addr = 16'd3;
    tick();
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk6("contend grant", fl(), (i == 4 || i == 9) ? FACK : DACK);
      chk16("contend rdata", (i == 4 || i == 9) ? bus.f_rdata : bus.d_rdata,
            (i == 4 || i == 9) ? 16'h1003 : 16'hBEEF);
      if (i < 9) repeat (3) tick();
    end
    bus.d_req = 1'b0;
    bus.f_req = 1'b0;
    tick();
    chk6("contend done", fl(), NONE);
    bus.f_req = 1'b1;
    bus.f_addr = 16'd2;
    tick();
    chk6("rst fetch issue", fl(), RD);
    reset = 1'b1;
    tick();
    chk6("rst dropped flags", fl(), NONE);
    chk16("rst dropped buses", bus.mem_addr | bus.f_rdata | bus.d_rdata, 16'd0);
    reset = 1'b0;
    tick();
    chk6("reissue issue", fl(), RD);
    chk16("reissue addr", bus.mem_addr, 16'd2);
    tick();
    chk6("reissue ack", fl(), FACK);
    chk16("reissue rdata", bus.f_rdata, 16'h1002);
    bus.f_req = 1'b0;
    tick();
    chk6("final idle", fl(), NONE);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
